ret_stack: RTL and testbench
============================

Name: ret_stack

Overview:
- Multi-entry hardware return-address stack that replaces the single-entry linked_reg.
- Sits beside pc, downstream of decoder: consumes cal/ret from decoder and instr_addr from pc, and produces ret_addr back to pc.
- Supports nested calls up to DEPTH levels.
- Detects overflow and underflow and enters a sticky FAULT state.

Parameters:
- PC_SIZE, 5, width of instruction addresses (matches pc INSTR_ADDR_SIZE).
- DEPTH, 8, number of stack entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cal  input  1  call: push return address (instr_addr + 1).
- ret  input  1  return: pop top entry.
- clr  input  1  synchronous clear: empty stack, drop flags, leave FAULT.
- instr_addr  input  PC_SIZE  address of the instruction currently executing.
- ret_addr  output  PC_SIZE  current top-of-stack entry; 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH+1)  number of valid entries.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- fault  output  1  high in FAULT state.

Behaviour:
- Reset (rst low, asynchronous): count=0, write pointer=0, ret_addr=0, overflow=0, underflow=0, state=RUN. Entry array contents are don't-care.
- Push value = (instr_addr + 1) mod 2^PC_SIZE, so 31+1 wraps to 0.
- ret_addr is the registered top entry.
  - Valid in the cycle after the push or pop edge, so pc sees the correct value in the same cycle ret is asserted.
  - Returns 0 whenever empty.
- States: RUN, FAULT.
- RUN, per rising edge; priority is clr > (cal,ret):
  - clr=1: count=0, flags cleared, stay RUN.
  - cal=1, ret=0, not full: store the push value, count+1, top updated.
  - cal=0, ret=1, not empty: count-1, top becomes the next entry (0 if now empty).
  - cal=1, ret=1, not empty: replace top with the push value; count unchanged.
  - cal=1, ret=1, empty: underflow=1, push performed (count=1), go FAULT.
  - cal=1, ret=0, full: push dropped, overflow=1, go FAULT.
  - cal=0, ret=1, empty: underflow=1, ret_addr stays 0, go FAULT.
  - Neither asserted: hold.
- FAULT:
  - cal and ret ignored; count, entries and ret_addr frozen.
  - fault=1.
  - clr=1 → RUN with an empty stack and both flags cleared (takes effect at the next edge).
- Entry storage: DEPTH x PC_SIZE register array indexed by the pointer; the pointer wraps modulo DEPTH.
- Reset asserted mid-operation overrides everything immediately; no pending push survives.
- full and empty are combinational decodes of count.

Optional Feature:
- Macro: RET_STACK_CIRCULAR_EN.
- Defined:
  - cal while full (without ret) overwrites the oldest entry. The pointer advances modulo DEPTH, count stays DEPTH, the new value becomes top.
  - overflow is never set and no FAULT is entered on overflow.
  - Underflow handling is unchanged.
- Undefined: overflow behaviour as in Behaviour (drop, flag, FAULT).

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release → count=0, empty=1, ret_addr=0, fault=0.
- Nested calls: cal at instr_addr=3, 10, 20 on successive cycles → count=3, ret_addr=21. Then three single-cycle ret pulses → ret_addr=11, then 4, then 0 with empty=1.
- Wrap arithmetic: cal at instr_addr=31 → ret_addr=0, count=1.
- Overflow (macro undefined, DEPTH=8): 9 consecutive cal at instr_addr=k for k=0..8 → count=8, overflow=1, fault=1, ret_addr=8. A further ret is ignored. Then clr → count=0, overflow=0, fault=0.
- Underflow then simultaneous: ret while empty → underflow=1, fault=1. After clr, cal at 5, then cal+ret together at instr_addr=12 → count=1, ret_addr=13.
- Circular (RET_STACK_CIRCULAR_EN defined): 10 cal at instr_addr=0..9 → count=8, overflow=0. Then 8 ret pulses yield ret_addr 9,8,7,6,5,4,3, then empty=1 with ret_addr=0. Entries 1 and 2 were lost to the overwrite.

Source files
------------

// File: rtl/ret_stack_if.sv
// ret_stack_if: decoder/pc-side signal bundle of the return-address stack.
// The stack itself connects through the slave modport; the driver of
// cal/ret/clr/instr_addr (decoder + pc, or a testbench) uses master.
interface ret_stack_if #(
  parameter int PC_SIZE = 5,
  parameter int DEPTH   = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               cal;
  logic               ret;
  logic               clr;
  logic [PC_SIZE-1:0] instr_addr;
  logic [PC_SIZE-1:0] ret_addr;
  logic               empty;
  logic               full;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               underflow;
  logic               fault;

  modport master (
    output cal, ret, clr, instr_addr,
    input  ret_addr, empty, full, count, overflow, underflow, fault
  );

  modport slave (
    input  cal, ret, clr, instr_addr,
    output ret_addr, empty, full, count, overflow, underflow, fault
  );
endinterface

// File: rtl/ret_stack.sv
// ret_stack: multi-entry hardware return-address stack beside pc.
// cal pushes instr_addr+1, ret pops; ret_addr is the registered top entry
// (0 when empty). Overflow/underflow set sticky flags and park the stack in
// FAULT until clr.
// Optional build macro RET_STACK_CIRCULAR_EN: a push while full overwrites
// the oldest entry instead of faulting.
module ret_stack #(
  parameter int PC_SIZE = 5,
  parameter int DEPTH   = 8
) (
  input  logic         clk,
  input  logic         rst,
  ret_stack_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {RUN, FAULT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   ptr_q,   ptr_d;     // next free slot; top is ptr_q-1
  logic [PC_SIZE-1:0] top_q,   top_d;
  logic               ovf_q,   ovf_d;
  logic               unf_q,   unf_d;

  logic [PC_SIZE-1:0] mem_q [DEPTH];
  logic               mem_we;
  logic [PTR_W-1:0]   mem_wa;

  logic [PC_SIZE-1:0] push_val;
  logic [PC_SIZE-1:0] below_top;
  logic [PTR_W-1:0]   below_idx;
  logic               is_empty;
  logic               is_full;

  assign push_val  = bus.instr_addr + PC_SIZE'(1);   // wraps mod 2^PC_SIZE
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  assign below_idx = ptr_q - PTR_W'(2);
  // Entry that becomes top after a pop; 0 when the pop empties the stack.
  assign below_top = (count_q >= CNT_W'(2)) ? mem_q[below_idx] : '0;

  // Next-state and datapath decode; clr beats cal/ret, FAULT freezes all.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;

    if (bus.clr) begin
      state_d = RUN;
      count_d = '0;
      ptr_d   = '0;
      top_d   = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (state_q == RUN) begin
      if (bus.cal && bus.ret) begin
        if (is_empty) begin
          // Underflow still performs the push, then faults.
          mem_we  = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          count_d = CNT_W'(1);
          top_d   = push_val;
          unf_d   = 1'b1;
          state_d = FAULT;
        end else begin
          // Tail call: replace top in place.
          mem_we = 1'b1;
          mem_wa = ptr_q - PTR_W'(1);
          top_d  = push_val;
        end
      end else if (bus.cal) begin
        if (!is_full) begin
          mem_we  = 1'b1;
          ptr_d   = ptr_q + PTR_W'(1);
          count_d = count_q + CNT_W'(1);
          top_d   = push_val;
        end else begin
`ifdef RET_STACK_CIRCULAR_EN
          // Overwrite the oldest slot; the stack stays full.
          mem_we = 1'b1;
          ptr_d  = ptr_q + PTR_W'(1);
          top_d  = push_val;
`else
          ovf_d   = 1'b1;
          state_d = FAULT;
`endif
        end
      end else if (bus.ret) begin
        if (!is_empty) begin
          ptr_d   = ptr_q - PTR_W'(1);
          count_d = count_q - CNT_W'(1);
          top_d   = below_top;
        end else begin
          unf_d   = 1'b1;
          state_d = FAULT;
        end
      end
    end
  end

  // Control and top-of-stack registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= RUN;
      count_q <= '0;
      ptr_q   <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage.
  // NOTE: the array has no reset; count_q alone defines which entries are
  // valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= push_val;
  end

  assign bus.ret_addr  = top_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.fault     = (state_q == FAULT);
endmodule

// File: tb/tb_ret_stack.sv
// tb_ret_stack: scenario-based bench for ret_stack (PC_SIZE=5, DEPTH=8).
// Expected outputs come from the scenario tables, are queued when a cycle is
// driven and popped once the edge has produced the DUT result.
module tb_ret_stack;
  localparam int PC_SIZE = 5;
  localparam int DEPTH   = 8;

  typedef struct packed {
    logic [4:0] ra;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
    logic       flt;
  } exp_t;

  typedef struct packed {
    logic       c;
    logic       r;
    logic       cl;
    logic [4:0] a;
  } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  ret_stack_if #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH)) bus ();

  ret_stack #(.PC_SIZE(PC_SIZE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t E(int ra, int cnt, bit o, bit u, bit f);
    exp_t e;
    e.ra  = 5'(ra);
    e.cnt = 4'(cnt);
    e.emp = (cnt == 0);
    e.ful = (cnt == DEPTH);
    e.ovf = o;
    e.unf = u;
    e.flt = f;
    return e;
  endfunction

  function automatic stim_t S(bit c, bit r, bit cl, int a);
    stim_t s;
    s.c = c; s.r = r; s.cl = cl; s.a = 5'(a);
    return s;
  endfunction

  function automatic exp_t sample();
    exp_t o;
    o.ra  = bus.ret_addr;
    o.cnt = bus.count;
    o.emp = bus.empty;
    o.ful = bus.full;
    o.ovf = bus.overflow;
    o.unf = bus.underflow;
    o.flt = bus.fault;
    return o;
  endfunction

  // Apply one cycle of stimulus; outputs are valid 1 time unit after the edge.
  task automatic drive(input stim_t s);
    bus.cal        = s.c;
    bus.ret        = s.r;
    bus.clr        = s.cl;
    bus.instr_addr = s.a;
    @(posedge clk);
    #1;
    bus.cal = 1'b0;
    bus.ret = 1'b0;
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o, e;
    bus.cal = 1'b0; bus.ret = 1'b0; bus.clr = 1'b0; bus.instr_addr = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(E(0, 0, 0, 0, 0));
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_held: got %b expected %b", o, e);
    end
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(E(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_released: got %b expected %b", o, e);
    end
  endtask

  task automatic test_nested();
    stim_t st[6];
    exp_t  xp[6];
    exp_t  o, e;
    st = '{S(1,0,0,3), S(1,0,0,10), S(1,0,0,20), S(0,1,0,0), S(0,1,0,0), S(0,1,0,0)};
    xp = '{E(4,1,0,0,0), E(11,2,0,0,0), E(21,3,0,0,0),
           E(11,2,0,0,0), E(4,1,0,0,0), E(0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(xp[i]);
      drive(st[i]);
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL nested[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 i, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[2];
    exp_t  xp[2];
    exp_t  o, e;
    st = '{S(1,0,0,31), S(0,1,0,0)};
    xp = '{E(0,1,0,0,0), E(0,0,0,0,0)};
    for (int i = 0; i < 2; i++) begin
      sb.push_back(xp[i]);
      drive(st[i]);
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 i, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
  endtask

`ifndef RET_STACK_CIRCULAR_EN
  task automatic test_overflow();
    exp_t o, e;
    // Nine pushes of k+1; the ninth is dropped and faults.
    for (int k = 0; k < 9; k++) begin
      sb.push_back(k < 8 ? E(k + 1, k + 1, 0, 0, 0) : E(8, 8, 1, 0, 1));
      drive(S(1, 0, 0, k));
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL overflow_push[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 k, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
    // ret ignored in FAULT, clr recovers.
    sb.push_back(E(8, 8, 1, 0, 1));
    drive(S(0, 1, 0, 0));
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL overflow_ret_ignored: got %b expected %b", o, e);
    end
    sb.push_back(E(0, 0, 0, 0, 0));
    drive(S(0, 0, 1, 0));
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL overflow_clr: got %b expected %b", o, e);
    end
  endtask
`else
  task automatic test_circular();
    exp_t o, e;
    for (int k = 0; k < 10; k++) begin
      sb.push_back(E(k + 1, (k < 8) ? k + 1 : 8, 0, 0, 0));
      drive(S(1, 0, 0, k));
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL circular_push[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 k, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
    // Tops after each pop: 9..3, then empty (values 1 and 2 were overwritten).
    for (int k = 0; k < 8; k++) begin
      sb.push_back(k < 7 ? E(9 - k, 7 - k, 0, 0, 0) : E(0, 0, 0, 0, 0));
      drive(S(0, 1, 0, 0));
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL circular_pop[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 k, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
  endtask
`endif

  task automatic test_underflow();
    stim_t st[8];
    exp_t  xp[8];
    exp_t  o, e;
    st = '{S(0,1,0,0), S(1,0,0,9), S(0,0,1,0), S(1,0,0,5),
           S(1,1,0,12), S(0,1,0,0), S(1,1,0,7), S(0,0,1,0)};
    xp = '{E(0,0,0,1,1), E(0,0,0,1,1), E(0,0,0,0,0), E(6,1,0,0,0),
           E(13,1,0,0,0), E(0,0,0,0,0), E(8,1,0,1,1), E(0,0,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(xp[i]);
      drive(st[i]);
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL underflow[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 i, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[7];
    exp_t  xp[7];
    exp_t  o, e;
    st = '{S(1,0,0,1), S(1,0,0,2), S(0,1,0,0), S(1,0,0,6),
           S(1,1,0,8), S(0,1,0,0), S(0,1,0,0)};
    xp = '{E(2,1,0,0,0), E(3,2,0,0,0), E(2,1,0,0,0), E(7,2,0,0,0),
           E(9,2,0,0,0), E(2,1,0,0,0), E(0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      sb.push_back(xp[i]);
      drive(st[i]);
      e = sb.pop_front(); o = sample(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got ra=%0d cnt=%0d flags=%b expected ra=%0d cnt=%0d flags=%b",
                 i, o.ra, o.cnt, o[4:0], e.ra, e.cnt, e[4:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t o, e;
    sb.push_back(E(5, 1, 0, 0, 0));
    drive(S(1, 0, 0, 4));
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_mid_setup: got %b expected %b", o, e);
    end
    // Pending push in flight when reset hits between edges.
    bus.cal = 1'b1; bus.instr_addr = 5'd9;
    #2;
    rst = 1'b0;
    #1;
    sb.push_back(E(0, 0, 0, 0, 0));
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_mid_async: got %b expected %b", o, e);
    end
    @(posedge clk);
    #1;
    bus.cal = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(E(0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    e = sb.pop_front(); o = sample(); n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL reset_mid_release: got %b expected %b", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_nested();
    test_wrap();
`ifndef RET_STACK_CIRCULAR_EN
    test_overflow();
`else
    test_circular();
`endif
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
